gpio_pad_ctrl: RTL and testbench

Parametrised multi-channel GPIO controller that sits between the SoC register interface and a row of bidirectional IO cells in the padring. It registers per-channel direction and output drive, with push-pull or emulated open-drain mode. On the input side it synchronises, glitch-filters and edge-detects each channel. It raises sticky per-channel interrupts and a combined interrupt line. The IO cells themselves are instantiated at padring level; this block drives their `FROM_CORE`/cfg pins and consumes their `TO_CORE` pins.

---
 rtl/gpio_pad_pkg.sv | 7 +
 rtl/gpio_pad_ctrl_if.sv | 32 +++
 rtl/gpio_in_filter.sv | 46 ++++
 rtl/gpio_pad_ctrl.sv | 47 ++++
 tb/tb_gpio_pad_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared constants for the GPIO pad controller.
package gpio_pad_pkg;
   localparam int   CFG_DIR_BIT    = 0;
   localparam int   DEF_CONF_WIDTH = 3;
   localparam logic GPIO_DIR_IN    = 1'b1;
   localparam logic GPIO_DIR_OUT   = 1'b0;
endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if: register-side controls and IO-cell pins of the GPIO pad controller.
interface gpio_pad_ctrl_if
   import gpio_pad_pkg::*;
#(
   parameter int N_CH       = 8,
   parameter int CONF_WIDTH = DEF_CONF_WIDTH,
   parameter int FILT_W     = 4
);
   logic [N_CH-1:0]            dir_in;
   logic [N_CH-1:0]            od_en_in;
   logic [N_CH-1:0]            out_data_in;
   logic [FILT_W-1:0]          filt_len_in;
   logic [N_CH-1:0]            irq_rise_en_in;
   logic [N_CH-1:0]            irq_fall_en_in;
   logic [N_CH-1:0]            irq_clr_in;
   logic [N_CH-1:0]            cell_to_core_in;
   logic [N_CH-1:0]            cell_from_core_out;
   logic [N_CH*CONF_WIDTH-1:0] cell_cfg_out;
   logic [N_CH-1:0]            in_data_out;
   logic [N_CH-1:0]            irq_pending_out;
   logic                       irq_out;
   modport master (
      output dir_in, od_en_in, out_data_in, filt_len_in, irq_rise_en_in, irq_fall_en_in,
             irq_clr_in, cell_to_core_in,
      input  cell_from_core_out, cell_cfg_out, in_data_out, irq_pending_out, irq_out
   );
   modport slave (
      input  dir_in, od_en_in, out_data_in, filt_len_in, irq_rise_en_in, irq_fall_en_in,
             irq_clr_in, cell_to_core_in,
      output cell_from_core_out, cell_cfg_out, in_data_out, irq_pending_out, irq_out
   );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one channel's synchroniser, glitch filter, edge detect and sticky pending flag.
module gpio_in_filter
   import gpio_pad_pkg::*;
#(
   parameter int FILT_W = 4
) (
   input  logic              clk_in,
   input  logic              reset_int,
   input  logic              pad_i,
   input  logic              dir_i,
   input  logic              rise_en_i,
   input  logic              fall_en_i,
   input  logic              clr_i,
   input  logic [FILT_W-1:0] filt_len_i,
   output logic              filt_o,
   output logic              pend_o
);
   logic              meta_q, sync_q, filt_q, filt_d, pend_q, pend_d, upd, set;
   logic [FILT_W-1:0] cnt_q, cnt_d, thr;
   // cnt holds how many earlier edges already saw sync differ, so the current one completes max(L,1)
   always_comb begin
      thr    = (filt_len_i == '0) ? '0 : filt_len_i - 1'b1;
      upd    = (sync_q != filt_q) && (cnt_q >= thr);
      filt_d = upd ? sync_q : filt_q;
      cnt_d  = (sync_q == filt_q || upd) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      set    = upd && (dir_i == GPIO_DIR_IN) && (sync_q ? rise_en_i : fall_en_i);
      pend_d = set ? 1'b1 : clr_i ? 1'b0 : pend_q;
   end
   always_ff @(posedge clk_in) begin
      if (!reset_int) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         meta_q <= pad_i;
         sync_q <= meta_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end
   assign filt_o = filt_q;
   assign pend_o = pend_q;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: registered push-pull/open-drain drive mux plus per-channel filtered inputs and interrupts.
module gpio_pad_ctrl
   import gpio_pad_pkg::*;
#(
   parameter int N_CH       = 8,
   parameter int CONF_WIDTH = DEF_CONF_WIDTH,
   parameter int FILT_W     = 4
) (
   input logic            clk_in,
   input logic            reset_int,
   gpio_pad_ctrl_if.slave bus_io
);
   logic [N_CH-1:0] cfg_dir_q, cfg_dir_d, from_q, from_d, filt, pend;
   // open-drain emulation: the cell's direction bit becomes the data, releasing the pad for a 1
   always_comb begin
      cfg_dir_d = bus_io.dir_in | (bus_io.od_en_in & bus_io.out_data_in);
      from_d    = ~bus_io.dir_in & ~bus_io.od_en_in & bus_io.out_data_in;
   end
   always_ff @(posedge clk_in) begin
      if (!reset_int) begin
         cfg_dir_q <= {N_CH{GPIO_DIR_IN}};
         from_q    <= '0;
      end else begin
         cfg_dir_q <= cfg_dir_d;
         from_q    <= from_d;
      end
   end
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      gpio_in_filter #(.FILT_W(FILT_W)) u_filt (
         .clk_in     (clk_in),
         .reset_int  (reset_int),
         .pad_i      (bus_io.cell_to_core_in[k]),
         .dir_i      (bus_io.dir_in[k]),
         .rise_en_i  (bus_io.irq_rise_en_in[k]),
         .fall_en_i  (bus_io.irq_fall_en_in[k]),
         .clr_i      (bus_io.irq_clr_in[k]),
         .filt_len_i (bus_io.filt_len_in),
         .filt_o     (filt[k]),
         .pend_o     (pend[k])
      );
      assign bus_io.cell_cfg_out[k*CONF_WIDTH +: CONF_WIDTH] = CONF_WIDTH'(cfg_dir_q[k]) << CFG_DIR_BIT;
   end
   assign bus_io.cell_from_core_out = from_q;
   assign bus_io.in_data_out        = filt;
   assign bus_io.irq_pending_out    = pend;
   assign bus_io.irq_out            = |pend;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed and random stimulus against a window-based reference model of the pad controller.
module tb_gpio_pad_ctrl;
   localparam int N  = 8;
   localparam int CW = 3;
   localparam int FW = 4;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int n;
   gpio_pad_ctrl_if #(.N_CH(N), .CONF_WIDTH(CW), .FILT_W(FW)) bus ();
   gpio_pad_ctrl #(.N_CH(N), .CONF_WIDTH(CW), .FILT_W(FW)) dut (
      .clk_in    (clk),
      .reset_int (rst_n),
      .bus_io    (bus.slave)
   );
   always #5 clk = ~clk;
   logic [N-1:0] m_s1, m_s2, m_filt, m_pend, m_cfg0, m_from;
   bit hist[N][$];
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // filt follows sync once the last max(L,1) sampled sync values all disagree with it
   task automatic model_step();
      int  leff;
      bit  run;
      bit  set;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_filt = '0; m_pend = '0; m_cfg0 = '1; m_from = '0;
         for (int c = 0; c < N; c++) begin
            hist[c].delete();
            repeat (16) hist[c].push_back(1'b0);
         end
      end else begin
         leff = (bus.filt_len_in == 0) ? 1 : int'(bus.filt_len_in);
         for (int c = 0; c < N; c++) begin
            hist[c].push_back(m_s2[c]);
            void'(hist[c].pop_front());
            run = 1'b1;
            for (int i = 0; i < leff; i++) if (hist[c][15-i] == m_filt[c]) run = 1'b0;
            set = run && bus.dir_in[c] && (m_s2[c] ? bus.irq_rise_en_in[c] : bus.irq_fall_en_in[c]);
            m_pend[c] = set | (m_pend[c] & ~bus.irq_clr_in[c]);
            if (run) m_filt[c] = m_s2[c];
            m_cfg0[c] = bus.dir_in[c] ? 1'b1 : bus.od_en_in[c] ? bus.out_data_in[c] : 1'b0;
            m_from[c] = bus.dir_in[c] ? 1'b0 : bus.od_en_in[c] ? 1'b0 : bus.out_data_in[c];
         end
         m_s2 = m_s1;
         m_s1 = bus.cell_to_core_in;
      end
   endtask
   task automatic step(string tag);
      logic [N*CW-1:0] exp_cfg;
      @(posedge clk);
      model_step();
      #1;
      exp_cfg = '0;
      for (int c = 0; c < N; c++) exp_cfg[c*CW] = m_cfg0[c];
      chk({tag, ".in_data"}, bus.in_data_out, m_filt);
      chk({tag, ".pending"}, bus.irq_pending_out, m_pend);
      chk({tag, ".irq"}, bus.irq_out, |m_pend);
      chk({tag, ".from_core"}, bus.cell_from_core_out, m_from);
      chk({tag, ".cfg"}, bus.cell_cfg_out, exp_cfg);
   endtask
   initial begin
      bus.dir_in = '1; bus.od_en_in = '0; bus.out_data_in = '0; bus.filt_len_in = '0;
      bus.irq_rise_en_in = '0; bus.irq_fall_en_in = '0; bus.irq_clr_in = '0; bus.cell_to_core_in = '0;
      repeat (3) step("rst");
      rst_n = 1'b1;
      step("rel");
      chk("rel_cfg", bus.cell_cfg_out, {N{3'b001}});
      chk("rel_from", bus.cell_from_core_out, 0);
      chk("rel_in", bus.in_data_out, 0);
      chk("rel_irq", bus.irq_out, 0);
      bus.dir_in[0] = 1'b0; bus.out_data_in[0] = 1'b1;
      step("pp");
      chk("pp_cfg0", bus.cell_cfg_out[0], 0);
      chk("pp_from0", bus.cell_from_core_out[0], 1);
      bus.od_en_in[0] = 1'b1;
      step("od1");
      chk("od1_cfg0", bus.cell_cfg_out[0], 1);
      chk("od1_from0", bus.cell_from_core_out[0], 0);
      bus.out_data_in[0] = 1'b0;
      step("od0");
      chk("od0_cfg0", bus.cell_cfg_out[0], 0);
      chk("od0_from0", bus.cell_from_core_out[0], 0);
      bus.filt_len_in = 4'd4; bus.cell_to_core_in[1] = 1'b1;
      repeat (3) step("pulse");
      bus.cell_to_core_in[1] = 1'b0;
      repeat (8) begin
         step("pulse_tail");
         chk("pulse_in1", bus.in_data_out[1], 0);
      end
      bus.cell_to_core_in[1] = 1'b1;
      n = 0;
      while (bus.in_data_out[1] !== 1'b1 && n < 20) begin step("held"); n++; end
      chk("lat_L4", n, 6);
      repeat (4) step("held");
      bus.cell_to_core_in[1] = 1'b0;
      repeat (8) step("held_fall");
      bus.filt_len_in = 4'd0; bus.irq_rise_en_in[2] = 1'b1; bus.cell_to_core_in[2] = 1'b1;
      repeat (3) step("rise2");
      chk("rise_pend2", bus.irq_pending_out[2], 1);
      chk("rise_irq", bus.irq_out, 1);
      bus.irq_fall_en_in[2] = 1'b1; bus.cell_to_core_in[2] = 1'b0;
      repeat (2) step("fall2");
      bus.irq_clr_in[2] = 1'b1;
      step("setwins");
      bus.irq_clr_in[2] = 1'b0;
      chk("setwins_in2", bus.in_data_out[2], 0);
      chk("setwins_pend2", bus.irq_pending_out[2], 1);
      bus.irq_clr_in[2] = 1'b1;
      step("clr2");
      bus.irq_clr_in[2] = 1'b0;
      chk("clr_pend2", bus.irq_pending_out[2], 0);
      chk("clr_irq", bus.irq_out, 0);
      bus.irq_fall_en_in[3] = 1'b1; bus.cell_to_core_in[3] = 1'b1;
      repeat (4) step("dir3_in");
      bus.dir_in[3] = 1'b0; bus.cell_to_core_in[3] = 1'b0;
      repeat (5) step("dir3_out");
      chk("dirchg_in3", bus.in_data_out[3], 0);
      chk("dirchg_pend3", bus.irq_pending_out[3], 0);
      bus.filt_len_in = 4'd8; bus.cell_to_core_in[4] = 1'b1;
      repeat (7) step("midfilt");
      rst_n = 1'b0;
      step("midrst");
      rst_n = 1'b1;
      chk("midrst_in4", bus.in_data_out[4], 0);
      chk("midrst_cfg", bus.cell_cfg_out, {N{3'b001}});
      chk("midrst_pend", bus.irq_pending_out, 0);
      n = 0;
      while (bus.in_data_out[4] !== 1'b1 && n < 30) begin step("postrst"); n++; end
      chk("lat_rst_L8", n, 10);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) bus.dir_in = N'($urandom);
         if ($urandom_range(3) == 0) bus.od_en_in = N'($urandom);
         if ($urandom_range(1) == 0) bus.out_data_in = N'($urandom);
         if ($urandom_range(19) == 0) bus.filt_len_in = FW'($urandom_range(5));
         if ($urandom_range(9) == 0) bus.irq_rise_en_in = N'($urandom);
         if ($urandom_range(9) == 0) bus.irq_fall_en_in = N'($urandom);
         bus.irq_clr_in = N'($urandom & $urandom & $urandom);
         bus.cell_to_core_in ^= N'($urandom & $urandom);
         rst_n = ($urandom_range(99) != 0);
         step("rnd");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
